// File: rtl/midi_note_parser.sv
// MIDI channel-voice parser: extracts note-on/note-off events from a MIDI byte
// stream, with running status, channel masking and real-time transparency.
module midi_note_parser #(
  parameter logic [15:0] CHANNEL_MASK = 16'h0001,
  parameter logic        VEL0_IS_OFF  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       byteValid_i,
  input  logic [7:0] byte_i,
  output logic [6:0] note_o,
  output logic [6:0] velocity_o,
  output logic [3:0] channel_o,
  output logic       noteOnStrb_o,
  output logic       noteOffStrb_o,
  output logic       orphanStrb_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       rsValid_q, rsValid_d;
  logic       seenStatus_q, seenStatus_d;
  logic [3:0] cmd_q, cmd_d;
  logic [3:0] ch_q, ch_d;
  logic [6:0] noteLat_q, noteLat_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic [3:0] chOut_q, chOut_d;
  logic       onStrb_q, onStrb_d;
  logic       offStrb_q, offStrb_d;
  logic       orphan_q, orphan_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rsValid_q    <= 1'b0;
      seenStatus_q <= 1'b0;
      cmd_q        <= '0;
      ch_q         <= '0;
      noteLat_q    <= '0;
      note_q       <= '0;
      vel_q        <= '0;
      chOut_q      <= '0;
      onStrb_q     <= 1'b0;
      offStrb_q    <= 1'b0;
      orphan_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsValid_q    <= rsValid_d;
      seenStatus_q <= seenStatus_d;
      cmd_q        <= cmd_d;
      ch_q         <= ch_d;
      noteLat_q    <= noteLat_d;
      note_q       <= note_d;
      vel_q        <= vel_d;
      chOut_q      <= chOut_d;
      onStrb_q     <= onStrb_d;
      offStrb_q    <= offStrb_d;
      orphan_q     <= orphan_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rsValid_d    = rsValid_q;
    seenStatus_d = seenStatus_q;
    cmd_d        = cmd_q;
    ch_d         = ch_q;
    noteLat_d    = noteLat_q;
    note_d       = note_q;
    vel_d        = vel_q;
    chOut_d      = chOut_q;
    onStrb_d     = 1'b0;
    offStrb_d    = 1'b0;
    orphan_d     = 1'b0;

    if (!(state_q inside {IDLE, DATA1, DATA2})) begin
      state_d   = IDLE;
      rsValid_d = 1'b0;
    end else if (byteValid_i) begin
      if (byte_i[7:3] == 5'b11111) begin
        // real-time bytes pass through without disturbing the message
      end else if (byte_i[7:4] == 4'hF) begin
        rsValid_d    = 1'b0;
        state_d      = IDLE;
        seenStatus_d = 1'b1;
      end else if (byte_i[7]) begin
        cmd_d        = byte_i[7:4];
        ch_d         = byte_i[3:0];
        seenStatus_d = 1'b1;
        if ((byte_i[7:4] == 4'h8 || byte_i[7:4] == 4'h9) && CHANNEL_MASK[byte_i[3:0]]) begin
          rsValid_d = 1'b1;
          state_d   = DATA1;
        end else begin
          rsValid_d = 1'b0;
          state_d   = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (!rsValid_q && !seenStatus_q) orphan_d = 1'b1;
          end
          DATA1: begin
            noteLat_d = byte_i[6:0];
            state_d   = DATA2;
          end
          DATA2: begin
            note_d  = noteLat_q;
            vel_d   = byte_i[6:0];
            chOut_d = ch_q;
            if (cmd_q == 4'h8) offStrb_d = 1'b1;
            else if (byte_i[6:0] == '0 && VEL0_IS_OFF) offStrb_d = 1'b1;
            else onStrb_d = 1'b1;
            state_d = DATA1;
          end
          default: begin
            state_d   = IDLE;
            rsValid_d = 1'b0;
          end
        endcase
      end
    end
  end

  assign note_o        = note_q;
  assign velocity_o    = vel_q;
  assign channel_o     = chOut_q;
  assign noteOnStrb_o  = onStrb_q;
  assign noteOffStrb_o = offStrb_q;
  assign orphanStrb_o  = orphan_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Bench for midi_note_parser: three parameterisations share one byte stream and
// are checked every cycle against a message-level model plus literal spot checks.
module tb_midi_note_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bv  = 1'b0;
  logic [7:0] b   = 8'h00;

  logic [2:0][6:0] d_note;
  logic [2:0][6:0] d_vel;
  logic [2:0][3:0] d_ch;
  logic [2:0]      d_on, d_off, d_orph;

  localparam logic [15:0] MASKS [3] = '{16'h0001, 16'h0022, 16'hFFFF};
  localparam logic        V0OFF [3] = '{1'b1, 1'b1, 1'b0};

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  always #5 clk = ~clk;

  midi_note_parser #(.CHANNEL_MASK(16'h0001), .VEL0_IS_OFF(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst), .byteValid_i(bv), .byte_i(b),
    .note_o(d_note[0]), .velocity_o(d_vel[0]), .channel_o(d_ch[0]),
    .noteOnStrb_o(d_on[0]), .noteOffStrb_o(d_off[0]), .orphanStrb_o(d_orph[0]));

  midi_note_parser #(.CHANNEL_MASK(16'h0022), .VEL0_IS_OFF(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .byteValid_i(bv), .byte_i(b),
    .note_o(d_note[1]), .velocity_o(d_vel[1]), .channel_o(d_ch[1]),
    .noteOnStrb_o(d_on[1]), .noteOffStrb_o(d_off[1]), .orphanStrb_o(d_orph[1]));

  midi_note_parser #(.CHANNEL_MASK(16'hFFFF), .VEL0_IS_OFF(1'b0)) u2 (
    .clk_i(clk), .rst_i(rst), .byteValid_i(bv), .byte_i(b),
    .note_o(d_note[2]), .velocity_o(d_vel[2]), .channel_o(d_ch[2]),
    .noteOnStrb_o(d_on[2]), .noteOffStrb_o(d_off[2]), .orphanStrb_o(d_orph[2]));

  // Model: running status (cmd/ch/valid) plus count of data bytes collected
  logic       m_rs   [3] = '{default: 1'b0};
  logic       m_seen [3] = '{default: 1'b0};
  int         m_cnt  [3] = '{default: 0};
  logic [3:0] m_cmd  [3] = '{default: 4'h0};
  logic [3:0] m_chs  [3] = '{default: 4'h0};
  logic [6:0] m_lat  [3] = '{default: 7'h0};
  logic [6:0] e_note [3] = '{default: 7'h0};
  logic [6:0] e_vel  [3] = '{default: 7'h0};
  logic [3:0] e_ch   [3] = '{default: 4'h0};
  logic       e_on   [3] = '{default: 1'b0};
  logic       e_off  [3] = '{default: 1'b0};
  logic       e_orph [3] = '{default: 1'b0};

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_rs[d] = 0; m_seen[d] = 0; m_cnt[d] = 0; m_cmd[d] = 0; m_chs[d] = 0;
        e_note[d] = 0; e_vel[d] = 0; e_ch[d] = 0;
        e_on[d] = 0; e_off[d] = 0; e_orph[d] = 0;
      end else begin
        e_on[d] = 0; e_off[d] = 0; e_orph[d] = 0;
        if (bv) begin
          if (b >= 8'hF8) begin
          end else if (b >= 8'hF0) begin
            m_rs[d] = 0; m_cnt[d] = 0; m_seen[d] = 1;
          end else if (b >= 8'h80) begin
            m_seen[d] = 1; m_cmd[d] = b[7:4]; m_chs[d] = b[3:0]; m_cnt[d] = 0;
            m_rs[d] = (b[7:4] == 4'h8 || b[7:4] == 4'h9) && MASKS[d][b[3:0]];
          end else if (!m_rs[d]) begin
            e_orph[d] = !m_seen[d];
          end else if (m_cnt[d] == 0) begin
            m_lat[d] = b[6:0]; m_cnt[d] = 1;
          end else begin
            e_note[d] = m_lat[d]; e_vel[d] = b[6:0]; e_ch[d] = m_chs[d];
            m_cnt[d] = 0;
            if (m_cmd[d] == 4'h8 || (b[6:0] == 0 && V0OFF[d])) e_off[d] = 1;
            else e_on[d] = 1;
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[u%0d] t=%0t got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      cmp("note", d, 16'(d_note[d]), 16'(e_note[d]));
      cmp("vel", d, 16'(d_vel[d]), 16'(e_vel[d]));
      cmp("ch", d, 16'(d_ch[d]), 16'(e_ch[d]));
      cmp("on", d, 16'(d_on[d]), 16'(e_on[d]));
      cmp("off", d, 16'(d_off[d]), 16'(e_off[d]));
      cmp("orphan", d, 16'(d_orph[d]), 16'(e_orph[d]));
    end
  end

  // Drives from negedge+1; returns at negedge+1 after the capturing edge
  task automatic send(input logic [7:0] v);
    bv = 1'b1; b = v;
    @(negedge clk); #1;
    bv = 1'b0;
  endtask

  task automatic lit(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    cmp(name, d, act, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    lit("rst_note", 0, 16'(d_note[0]), 16'h0);
    lit("rst_strobes", 0, 16'({d_on[0], d_off[0], d_orph[0]}), 16'h0);

    send(8'h90); send(8'h3C); send(8'h64);
    lit("on1", 0, 16'(d_on[0]), 16'h1);
    lit("on1_note", 0, 16'(d_note[0]), 16'h3C);
    lit("on1_vel", 0, 16'(d_vel[0]), 16'h64);
    lit("on1_ch", 0, 16'(d_ch[0]), 16'h0);
    lit("on1_masked", 1, 16'(d_on[1]), 16'h0);

    send(8'h40); send(8'h7F);
    lit("rs_on", 0, 16'(d_on[0]), 16'h1);
    lit("rs_note", 0, 16'(d_note[0]), 16'h40);

    send(8'h80); send(8'h3C); send(8'h00);
    lit("off_strb", 0, 16'({d_on[0], d_off[0]}), 16'h1);

    send(8'h91); send(8'h45); send(8'h00);
    lit("v0_off", 1, 16'({d_on[1], d_off[1]}), 16'h1);
    lit("v0_off_ch", 1, 16'(d_ch[1]), 16'h1);
    lit("v0_on", 2, 16'({d_on[2], d_off[2]}), 16'h2);
    lit("v0_on_vel", 2, 16'(d_vel[2]), 16'h0);

    send(8'h92); send(8'h30); send(8'h40);
    lit("filt_strb", 0, 16'({d_on[0], d_off[0]}), 16'h0);
    lit("filt_note", 0, 16'(d_note[0]), 16'h3C);

    send(8'hB0); send(8'h07); send(8'h7F);
    lit("cc_orphan", 0, 16'(d_orph[0]), 16'h0);

    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
    lit("rt_on", 0, 16'(d_on[0]), 16'h1);
    lit("rt_note", 0, 16'(d_note[0]), 16'h3C);

    send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
    lit("sys_abort", 0, 16'({d_on[0], d_off[0], d_orph[0]}), 16'h0);

    send(8'h90); send(8'h3C); send(8'h85); send(8'h3D); send(8'h10);
    lit("abort_off", 1, 16'({d_on[1], d_off[1]}), 16'h1);
    lit("abort_note", 1, 16'(d_note[1]), 16'h3D);
    lit("abort_ch", 1, 16'(d_ch[1]), 16'h5);

    send(8'h90); @(negedge clk); #1;
    send(8'h3C); repeat (2) @(negedge clk); #1;
    send(8'h64);
    lit("gap_on", 0, 16'(d_on[0]), 16'h1);

    send(8'h90); send(8'h3C);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    lit("rst_mid_note", 0, 16'(d_note[0]), 16'h0);
    send(8'h64);
    lit("orphan", 0, 16'({d_on[0], d_off[0], d_orph[0]}), 16'h1);
    lit("orphan_u2", 2, 16'(d_orph[2]), 16'h1);

    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
